// File: rtl/dmem_responder_if.sv
// Beta <-> data-memory handshake bundle: load/store requests, data and completion strobes.
// The master drives requests; the slave (dmem_responder) returns read data and completions.
interface dmem_responder_if;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic        MemReadDone;
    logic        MemWriteReady;
    logic [31:0] memReadData;
    logic        MemReadReady;
    logic        MemWriteDone;

    modport master (
        output memAddr, memWriteData, MemRead, MemWrite, MemReadDone, MemWriteReady,
        input  memReadData, MemReadReady, MemWriteDone
    );

    modport slave (
        input  memAddr, memWriteData, MemRead, MemWrite, MemReadDone, MemWriteReady,
        output memReadData, MemReadReady, MemWriteDone
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory for the Beta: one load or store in flight,
// completed with a four-phase ready/done handshake. Current FSM state is exported on dbg_state.
module dmem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             busy,
    output logic [2:0]       dbg_state
);
    localparam int DEPTH = 1 << ADDR_BITS;

    // Handshake: MemReadReady stays high until MemReadDone rises, and the bus returns to
    // idle only after MemReadDone falls again; MemWriteDone mirrors this against MemWriteReady.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_READY = 3'd2,
        RD_REL   = 3'd3,
        WR_WAIT  = 3'd4,
        WR_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   mem_we;
    logic [31:0]            mem_q [DEPTH];

    logic [ADDR_BITS-1:0]   req_idx;
    logic                   unused_addr;

    assign req_idx     = bus.memAddr[ADDR_BITS+1:2];
    assign unused_addr = ^{bus.memAddr[31:ADDR_BITS+2], bus.memAddr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // A store without valid data blocks the bus; it must not let a read slip past.
                if (bus.MemWrite) begin
                    if (bus.MemWriteReady) begin
                        idx_d   = req_idx;
                        wdata_d = bus.memWriteData;
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = WR_WAIT;
                    end
                end else if (bus.MemRead) begin
                    idx_d   = req_idx;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = mem_q[idx_q];
                    state_d = RD_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_READY: begin
                if (bus.MemReadDone) state_d = RD_REL;
            end
            RD_REL: begin
                if (!bus.MemReadDone) state_d = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    mem_we  = 1'b1;
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_DONE: begin
                if (!bus.MemWriteReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset; an aborted store never reaches here because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end

    assign bus.memReadData  = rdata_q;
    assign bus.MemReadReady = (state_q == RD_READY);
    assign bus.MemWriteDone = (state_q == WR_DONE);
    assign busy             = (state_q != IDLE);
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: drivers issue loads/stores, a negedge monitor pops the
// expected read data queue whenever MemReadReady rises.
module tb_dmem_responder;
    localparam int LAT = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [2:0] dbg_state;

    dmem_responder_if dif();

    dmem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (dif),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: read data compared on the rising MemReadReady, then held stable while ready.
    logic        prev_rdy = 1'b0;
    logic [31:0] held     = '0;
    logic [31:0] exp_val;
    always @(negedge clk) begin
        if (reset) begin
            check("ready_done_excl", {31'b0, dif.MemReadReady & dif.MemWriteDone}, 32'd0);
            if (dif.MemReadReady && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_read: got %h expected no response", dif.memReadData);
                end else begin
                    exp_val = exp_q.pop_front();
                    check("read_data", dif.memReadData, exp_val);
                end
                held = dif.memReadData;
            end else if (dif.MemReadReady) begin
                check("read_hold", dif.memReadData, held);
            end
        end
        prev_rdy = dif.MemReadReady;
    end

    // Called right after the accepting edge; scrambles bus inputs until completion shows.
    task automatic wait_done(input bit rd, output int cyc);
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            if (rd ? dif.MemReadReady : dif.MemWriteDone) break;
            dif.MemRead      = 1'b0;
            dif.MemWrite     = 1'b0;
            dif.memAddr      = $urandom;
            dif.memWriteData = $urandom;
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 50) @(negedge clk);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit also_read);
        int cyc;
        dif.memAddr       = addr;
        dif.memWriteData  = data;
        dif.MemWrite      = 1'b1;
        dif.MemWriteReady = 1'b1;
        dif.MemRead       = also_read;
        @(posedge clk);
        wait_done(1'b0, cyc);
        check("store_latency", cyc, LAT);
        check("store_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("store_done_held", {31'b0, dif.MemWriteDone}, 32'd1);
        dif.MemWriteReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("store_done_drop", {31'b0, dif.MemWriteDone}, 32'd0);
        check("store_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp);
        int cyc;
        exp_q.push_back(exp);
        dif.memAddr = addr;
        dif.MemRead = 1'b1;
        @(posedge clk);
        wait_done(1'b1, cyc);
        check("load_latency", cyc, LAT);
        @(posedge clk);
        @(negedge clk);
        check("load_ready_held", {31'b0, dif.MemReadReady}, 32'd1);
        dif.MemReadDone = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("load_ready_drop", {31'b0, dif.MemReadReady}, 32'd0);
        check("load_rel_data", dif.memReadData, exp);
        check("load_rel_busy", {31'b0, busy}, 32'd1);
        dif.MemReadDone = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("load_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_rdy"}, {31'b0, dif.MemReadReady}, 32'd0);
        check({tag, "_wdone"}, {31'b0, dif.MemWriteDone}, 32'd0);
        check({tag, "_rdata"}, dif.memReadData, 32'd0);
        check({tag, "_state"}, {29'b0, dbg_state}, 32'd0);
    endtask

    initial begin
        dif.memAddr       = '0;
        dif.memWriteData  = '0;
        dif.MemRead       = 1'b0;
        dif.MemWrite      = 1'b0;
        dif.MemReadDone   = 1'b0;
        dif.MemWriteReady = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First edge out of reset accepts the store.
        do_store(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_load(32'h0000_0010, 32'hDEAD_BEEF);

        // Simultaneous load and store: store wins.
        do_store(32'h0000_0020, 32'h1234_5678, 1'b1);
        do_load(32'h0000_0020, 32'h1234_5678);

        // Index wraps modulo depth.
        do_store(32'h0000_0410, 32'hCAFE_F00D, 1'b0);
        do_load(32'h0000_0010, 32'hCAFE_F00D);

        // Store without valid data stalls everything, including a pending read.
        dif.MemWrite = 1'b1;
        dif.MemRead  = 1'b1;
        dif.memAddr  = 32'h0000_0020;
        repeat (3) @(negedge clk);
        check("stall_no_accept", {31'b0, busy}, 32'd0);
        dif.MemWrite = 1'b0;
        dif.MemRead  = 1'b0;

        do_store(32'h0000_0030, 32'h1111_1111, 1'b0);
        do_load(32'h0000_0030, 32'h1111_1111);

        // Store aborted by reset inside WR_WAIT.
        dif.memAddr       = 32'h0000_0030;
        dif.memWriteData  = 32'h2222_2222;
        dif.MemWrite      = 1'b1;
        dif.MemWriteReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.MemWrite = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("abort_wr");
        @(negedge clk);
        dif.MemWriteReady = 1'b0;
        reset = 1'b1;
        do_load(32'h0000_0030, 32'h1111_1111);

        // Load aborted by reset inside RD_WAIT.
        dif.memAddr = 32'h0000_0010;
        dif.MemRead = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.MemRead = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("abort_rd");
        @(negedge clk);
        reset = 1'b1;

        // High and byte-offset address bits are ignored.
        do_load(32'hFFFF_FC23, 32'h1234_5678);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: LATENCY, default 4, cycles from request acceptance to response; legal 2..15.
REQ-002 Parameter: ADDR_BITS, default 8, word-index width; memory depth 2^ADDR_BITS 32-bit words.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port: memAddr  input  32  byte address from Beta; word index = memAddr[ADDR_BITS+1:2].
REQ-006 Port: memWriteData  input  32  store data from Beta.
REQ-007 Port: MemRead  input  1  Beta load request.
REQ-008 Port: MemWrite  input  1  Beta store request.
REQ-009 Port: MemReadDone  input  1  Beta has consumed memReadData.
REQ-010 Port: MemWriteReady  input  1  Beta store data valid on memWriteData.
REQ-011 Port: memReadData  output  32  load data to Beta.
REQ-012 Port: MemReadReady  output  1  memReadData valid.
REQ-013 Port: MemWriteDone  output  1  store committed.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, RD_WAIT, RD_READY, RD_REL, WR_WAIT, WR_DONE.
REQ-016 IDLE: MemWrite=1 and MemWriteReady=1 SHALL latch memAddr index and memWriteData, load counter with LATENCY-1, go WR_WAIT.
REQ-017 IDLE: otherwise MemRead=1 SHALL latch memAddr index, load counter with LATENCY-1, go RD_WAIT; store has priority when both are requested.
REQ-018 IDLE with MemWrite=1 and MemWriteReady=0 SHALL remain IDLE; no read is started.
REQ-019 RD_WAIT: counter decrements each cycle; at 0 SHALL register RAM[latched index] into memReadData and go RD_READY.
REQ-020 RD_READY: MemReadReady=1, memReadData held stable; on MemReadDone=1 SHALL go RD_REL.
REQ-021 RD_REL: MemReadReady=0; memReadData still held; on MemReadDone=0 SHALL go IDLE.
REQ-022 WR_WAIT: counter decrements each cycle; at 0 SHALL write latched data to RAM[latched index] and go WR_DONE.
REQ-023 WR_DONE: MemWriteDone=1; on MemWriteReady=0 SHALL drop MemWriteDone and go IDLE.
REQ-024 Request-to-MemReadReady latency SHALL be exactly LATENCY cycles from the accepting edge; same for store to MemWriteDone.
REQ-025 Inputs memAddr/memWriteData changing after acceptance SHALL NOT affect the in-flight transaction.
REQ-026 Address bits above ADDR_BITS+1 and bits [1:0] SHALL be ignored (index wraps modulo depth).
REQ-027 A read of a word written by an earlier completed store SHALL return the stored value.
REQ-028 MemReadReady and MemWriteDone SHALL never be 1 together.
REQ-029 Back-to-back: a request present in the IDLE cycle following RD_REL or WR_DONE SHALL be accepted that cycle.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, MemReadReady=0, MemWriteDone=0, busy=0, memReadData=0, counter=0, independent of clk.
REQ-031 Reset mid-transaction SHALL abort it; an aborted store SHALL NOT modify RAM if reset asserts before its commit edge.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 First request SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-034 Store 0xDEADBEEF to 0x00000010 with MemWriteReady=1, LATENCY=4 -> MemWriteDone=1 4 cycles later, held until MemWriteReady=0, then 0 next edge.
REQ-035 Load 0x00000010 after REQ-034 -> MemReadReady=1 after 4 cycles with memReadData=0xDEADBEEF; held until MemReadDone=1; ready low next cycle.
REQ-036 MemRead=1 and MemWrite=1/MemWriteReady=1 same cycle, addr 0x20, data 0x12345678 -> store served first; subsequent load of 0x20 returns 0x12345678.
REQ-037 Store to 0x00000410 (ADDR_BITS=8) -> load from 0x00000010 returns same data (wrap).
REQ-038 reset=0 during RD_WAIT and during WR_WAIT -> outputs zero within same cycle, busy=0; aborted store leaves old RAM value.
REQ-039 Change memAddr/memWriteData every cycle during RD_WAIT/WR_WAIT -> result uses latched values only.
